// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux_rr_arbiter
//  Purpose  : Round-robin scheduler that shares one 4:1 NUM_OF_BITS-wide
//             selector datapath among four requesters. A programmable hold
//             limit bounds how long one requester may keep the shared word.
//
//  Ports    : clock  - system clock, all state updates on the rising edge
//             reset  - synchronous, active-high reset
//             REQ    - level request lines, REQ[i] belongs to requester i
//             A..D   - data words of requesters 0..3
//             GNT    - registered one-hot grant, zero when idle
//             SEL    - registered selector code of the current owner
//             OUT    - shared word, the owner's data while VALID, else 0
//             VALID  - registered, high while some requester owns OUT
//
//  Revision : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter #(
    parameter int NUM_OF_BITS = 4,
    parameter int HOLD_MAX    = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [3:0]             REQ,
    input  logic [NUM_OF_BITS-1:0] A,
    input  logic [NUM_OF_BITS-1:0] B,
    input  logic [NUM_OF_BITS-1:0] C,
    input  logic [NUM_OF_BITS-1:0] D,
    output logic [3:0]             GNT,
    output logic [1:0]             SEL,
    output logic [NUM_OF_BITS-1:0] OUT,
    output logic                   VALID
);

    // Hold counter must reach HOLD_MAX; one bit is enough when the limit is
    // disabled (the counter then only saturates and is never compared).
    localparam int                   c_CNT_W    = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [c_CNT_W-1:0]   c_HOLD_LIM = c_CNT_W'(HOLD_MAX);
    localparam logic [c_CNT_W-1:0]   c_HOLD_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]   c_HOLD_SAT = {c_CNT_W{1'b1}};

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BUSY = 1'b1;

    logic [0:0]         r_state;
    logic [3:0]         r_gnt;
    logic [1:0]         r_sel;
    logic               r_valid;
    logic [1:0]         r_last;
    logic [c_CNT_W-1:0] r_hold;

    logic [1:0]         w_base;
    logic [1:0]         w_idx;
    logic [1:0]         w_winner;
    logic               w_found;
    logic               w_any;
    logic               w_release;

    // The scan starts just after the most recent owner. In BUSY that is the
    // current owner, so it is naturally visited last and only wins again when
    // it is the sole requester left.
    assign w_base = (r_state == c_ST_BUSY) ? r_sel : r_last;
    assign w_any  = |REQ;

    always_comb begin
        w_winner = 2'd0;
        w_found  = 1'b0;
        w_idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            w_idx = w_base + k[1:0];
            if (!w_found && REQ[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end

    // Ownership ends when the owner lets go of its request or, with a nonzero
    // limit, once it has held the word for HOLD_MAX consecutive cycles.
    assign w_release = !REQ[r_sel] ||
                       ((HOLD_MAX != 0) && (r_hold == c_HOLD_LIM));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_gnt   <= 4'b0000;
            r_sel   <= 2'd0;
            r_valid <= 1'b0;
            r_hold  <= '0;
            r_last  <= 2'd3;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any) begin
                        r_state <= c_ST_BUSY;
                        r_gnt   <= 4'b0001 << w_winner;
                        r_sel   <= w_winner;
                        r_valid <= 1'b1;
                        r_hold  <= c_HOLD_ONE;
                        r_last  <= w_winner;
                    end
                end
                c_ST_BUSY: begin
                    if (!w_release) begin
                        if (r_hold != c_HOLD_SAT) begin
                            r_hold <= r_hold + 1'b1;
                        end
                    end else if (w_any) begin
                        // Hand over on the same edge: no idle bubble.
                        r_gnt   <= 4'b0001 << w_winner;
                        r_sel   <= w_winner;
                        r_valid <= 1'b1;
                        r_hold  <= c_HOLD_ONE;
                        r_last  <= w_winner;
                    end else begin
                        // SEL deliberately keeps the last owner's code.
                        r_state <= c_ST_IDLE;
                        r_gnt   <= 4'b0000;
                        r_valid <= 1'b0;
                        r_hold  <= '0;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_gnt   <= 4'b0000;
                    r_valid <= 1'b0;
                    r_hold  <= '0;
                end
            endcase
        end
    end

    assign GNT   = r_gnt;
    assign SEL   = r_sel;
    assign VALID = r_valid;

    // Data passes straight through while owned; forced to zero when idle.
    always_comb begin
        OUT = '0;
        if (r_valid) begin
            case (r_sel)
                2'd0:    OUT = A;
                2'd1:    OUT = B;
                2'd2:    OUT = C;
                default: OUT = D;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin scheduler that shares the 4-input, 4-bit selector datapath among four requesters.
- Each requester raises a request and presents its data word. The block decides which requester owns the shared output and drives the selector code.
- A programmable hold limit stops any single requester from starving the others.
- Sits between the requester blocks and the downstream consumer of the shared word.

Parameters:
NUM_OF_BITS, 4, data width of each requester word and of the shared output
HOLD_MAX, 4, maximum consecutive cycles one grant may last; 0 = unlimited (release only when the request drops)

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
REQ  input  4  request lines; REQ[i] belongs to requester i
A  input  NUM_OF_BITS  data word of requester 0
B  input  NUM_OF_BITS  data word of requester 1
C  input  NUM_OF_BITS  data word of requester 2
D  input  NUM_OF_BITS  data word of requester 3
GNT  output  4  one-hot grant, registered; all zero when idle
SEL  output  2  selector code of the current owner, registered
OUT  output  NUM_OF_BITS  shared word; combinational A/B/C/D chosen by SEL when VALID=1, else 0
VALID  output  1  registered; 1 while some requester owns OUT

Behaviour:
- Clock and reset are fixed: one clock, `clock`; reset is synchronous and active-high, `reset`.
- Reset, sampled at a rising edge, forces:
  - state=IDLE, GNT=0000, SEL=00, VALID=0, OUT=0;
  - hold counter=0;
  - round-robin pointer LAST=3, so requester 0 has top priority on the first arbitration.
- Reset mid-grant drops ownership on that same edge. There is no drain.
- FSM, two states:
  - IDLE: VALID=0.
    - If REQ!=0 at an edge, the winner is the first set REQ bit scanning (LAST+1) mod 4 upward with wrap.
    - Next state: BUSY, GNT=onehot(winner), SEL=winner, VALID=1, hold counter=1, LAST=winner.
    - If REQ=0, stay IDLE.
  - BUSY: owner = SEL.
    - Release condition: REQ[SEL]=0, or (HOLD_MAX!=0 and hold counter==HOLD_MAX).
    - No release: stay BUSY and increment the hold counter. Saturate the counter when HOLD_MAX=0; width is at least clog2(HOLD_MAX+1), minimum 1 bit.
    - Release with another pending request: re-arbitrate on the same edge with no idle bubble. The winner is the next set REQ bit scanning from SEL+1 with wrap.
    - The current owner is scanned last. If it still requests and no one else does (hold expiry case), it is re-granted and the hold counter returns to 1.
    - Release with no pending request: go to IDLE, GNT=0000, VALID=0. SEL keeps its last value.
- Latency:
  - A request sampled at edge t gets its grant visible after edge t, i.e. one cycle.
  - OUT follows data inputs combinationally during ownership, so data changes pass through with zero latency.
- Invariants:
  - GNT is always one-hot or zero.
  - GNT[SEL]==VALID.
  - OUT==0 whenever VALID=0.
- Requests are level, not pulse. A requester that drops REQ before being granted is simply skipped.
- Simultaneous requests: strict rotation from LAST+1. No requester waits more than 3 grants.
- X or unknown SEL is impossible after reset. There is no default data path other than 0 when idle.

Test Plan:
1. Reset, then REQ=0000 for 5 cycles -> GNT=0000, VALID=0, OUT=0, SEL=00 throughout.
2. Single requester: REQ=0100, C=4'hA held for 3 cycles, then dropped; HOLD_MAX=4 ->
   - one cycle after the first sample: GNT=0100, SEL=10, VALID=1, OUT=4'hA;
   - returns to IDLE (GNT=0000, OUT=0) one cycle after REQ drops.
3. Hold expiry, HOLD_MAX=4: REQ=0011 continuously, A=1, B=2 ->
   - GNT=0001 for 4 cycles (OUT=1), then GNT=0010 for 4 cycles (OUT=2), then back to 0001;
   - no cycle with VALID=0.
4. Full contention after reset: REQ=1111, HOLD_MAX=1 -> grant sequence 0001, 0010, 0100, 1000, 0001, one per cycle; SEL=00, 01, 10, 11, 00.
5. Lone owner re-grant, HOLD_MAX=2: REQ=1000 steady, D=4'hF -> GNT stays 1000, VALID stays 1 and OUT=4'hF on every cycle; the internal hold counter cycles 1, 2, 1, 2.
6. Reset mid-operation: owner B (GNT=0010, OUT=B) with REQ=0111, assert reset for 1 cycle ->
   - next cycle: GNT=0000, VALID=0, OUT=0;
   - after reset deasserts: requester 0 is granted first (GNT=0001).
